// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared type codes, state and owner encodings for mem_ctrl.
// The STALL state exists only when IO_STALL_EN is defined.
package mem_ctrl_pkg;
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } lsb_type_e;
    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
`ifdef IO_STALL_EN
        , STALL
`endif
    } state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        return size == 2'b00 ? 3'd1 : size == 2'b01 ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ext.sv
// mem_ext: size and sign/zero extension of assembled little-endian load bytes.
module mem_ext (
    input  logic [2:0]  typ,
    input  logic [31:0] raw,
    output logic [31:0] val
);
    always_comb
        val = typ[1:0] == 2'b00 ? {{24{~typ[2] & raw[7]}}, raw[7:0]} :
              typ[1:0] == 2'b01 ? {{16{~typ[2] & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests onto the byte-wide RAM/IO bus.
// Define IO_STALL_EN to hold IO-region stores while the UART buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_enable,
    input  logic [31:0] addr,
    input  logic [31:0] store_val,
    input  logic [3:0]  lsb_type,
    output logic        ls_finished,
    output logic [31:0] load_val
);
    state_e      state;
    owner_e      owner;
    logic [31:0] base, sdata, acc, raw, ext_val;
    logic [2:0]  typ, cnt, idx;
    logic        wr_q, cleared;

    // idx is the edge number since acceptance; byte idx-2 arrives on mem_din now
    assign raw    = acc | ({24'b0, mem_din} << {cnt - 3'd1, 3'b0});
    assign mem_wr = wr_q & rdy_in;

`ifndef IO_STALL_EN
    logic unused_io;
    assign unused_io = ^{io_buffer_full, IO_ADDR_HI};
`endif

    mem_ext u_ext (.typ(typ), .raw(raw), .val(ext_val));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            base        <= '0;
            sdata       <= '0;
            acc         <= '0;
            typ         <= '0;
            cnt         <= '0;
            idx         <= '0;
            cleared     <= 1'b0;
            wr_q        <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= '0;
            if_done     <= 1'b0;
            if_data     <= '0;
            ls_finished <= 1'b0;
            load_val    <= '0;
        end else if (rdy_in) begin
            if_done     <= 1'b0;
            ls_finished <= 1'b0;
            case (state)
                IDLE: if (!clear && (ls_enable || if_req)) begin
                    owner   <= ls_enable ? OWN_LS : OWN_IF;
                    base    <= ls_enable ? addr : if_addr;
                    mem_a   <= ls_enable ? addr : if_addr;
                    cnt     <= ls_enable ? byte_count(lsb_type[1:0]) : 3'd4;
                    typ     <= lsb_type[2:0];
                    sdata   <= store_val;
                    acc     <= '0;
                    idx     <= 3'd1;
                    cleared <= 1'b0;
`ifdef IO_STALL_EN
                    if (ls_enable && lsb_type[3] && addr[17:16] == IO_ADDR_HI && io_buffer_full) begin
                        state <= STALL;
                        idx   <= 3'd0;
                        wr_q  <= 1'b0;
                    end else
`endif
                    if (ls_enable && lsb_type[3]) begin
                        state    <= WRITE;
                        mem_dout <= store_val[7:0];
                        wr_q     <= 1'b1;
                    end else begin
                        state <= READ;
                        wr_q  <= 1'b0;
                    end
                end
                READ: if (clear) begin
                    state <= IDLE;
                    wr_q  <= 1'b0;
                end else begin
                    if (idx < cnt) mem_a <= base + {29'b0, idx};
                    if (idx >= 3'd2) acc <= acc | ({24'b0, mem_din} << {idx - 3'd2, 3'b0});
                    idx <= idx + 3'd1;
                    if (idx == cnt + 3'd1) begin
                        state <= IDLE;
                        if (owner == OWN_IF) begin
                            if_done <= 1'b1;
                            if_data <= raw;
                        end else begin
                            ls_finished <= 1'b1;
                            load_val    <= ext_val;
                        end
                    end
                end
                WRITE: begin
                    cleared <= cleared | clear;
                    if (idx == cnt) begin
                        state       <= IDLE;
                        wr_q        <= 1'b0;
                        ls_finished <= !(cleared || clear);
                    end else
`ifdef IO_STALL_EN
                    if (base[17:16] == IO_ADDR_HI && io_buffer_full) begin
                        state <= STALL;
                        wr_q  <= 1'b0;
                    end else
`endif
                    begin
                        mem_a    <= base + {29'b0, idx};
                        mem_dout <= sdata[{idx[1:0], 3'b0} +: 8];
                        idx      <= idx + 3'd1;
                    end
                end
`ifdef IO_STALL_EN
                STALL: begin
                    cleared <= cleared | clear;
                    if (!io_buffer_full) begin
                        state    <= WRITE;
                        wr_q     <= 1'b1;
                        mem_a    <= base + {29'b0, idx};
                        mem_dout <= sdata[{idx[1:0], 3'b0} +: 8];
                        idx      <= idx + 3'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a byte-array reference model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clear = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0, if_req = 1'b0, ls_enable = 1'b0;
    logic [31:0] if_addr = '0, addr = '0, store_val = '0;
    logic [3:0]  lsb_type = '0;
    logic        if_done, ls_finished;
    logic [31:0] if_data, load_val;

    logic [7:0]  ram [4096];
    logic [7:0]  model_mem [4096];
    logic [39:0] wq [$];
    int          n_checks = 0, n_errors = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .ls_enable(ls_enable), .addr(addr),
        .store_val(store_val), .lsb_type(lsb_type), .ls_finished(ls_finished),
        .load_val(load_val)
    );

    always #5 clk_in = ~clk_in;

    // RAM with one-cycle read latency, frozen together with the rest of the system by rdy_in
    always @(posedge clk_in) if (rdy_in) begin
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wq.push_back({mem_a, mem_dout});
        end
        mem_din <= ram[mem_a[11:0]];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w, ai;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            ai = a + i;
            w[8*i +: 8] = model_mem[ai[11:0]];
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] t, input logic [31:0] a);
        logic [31:0] w;
        longint v;
        w = model_word(a);
        if (t[1:0] == 2'b10) return w;
        v = t[1:0] == 2'b00 ? longint'(w[7:0]) : longint'(w[15:0]);
        if (!t[2] && t[1:0] == 2'b00 && v >= 128) v -= 256;
        if (!t[2] && t[1:0] == 2'b01 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic check_writes(input string tag, input logic [31:0] a, input logic [31:0] sv, input int n);
        logic [31:0] ai, sb;
        check({tag, "_cnt"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            ai = a + i;
            sb = sv >> (8 * i);
            check({tag, "_addr"}, wq[i][39:8], ai);
            check({tag, "_data"}, {24'b0, wq[i][7:0]}, {24'b0, sb[7:0]});
        end
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            sb = sv >> (8 * i);
            model_mem[ai[11:0]] = sb[7:0];
        end
    endtask

    task automatic count_pulses(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            tick();
            if (if_done || ls_finished) seen++;
        end
    endtask

    task automatic do_ls(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sv);
        int n, lat;
        n = t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
        wq.delete();
        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = t; addr = a; store_val = sv;
        lat = 0;
        do begin
            tick();
            lat++;
            if (!t[3] && lat <= n) check("ld_addr", mem_a, a + lat - 1);
        end while (!ls_finished && lat < 20);
        check("ls_latency", lat, t[3] ? n + 1 : n + 2);
        if (t[3]) begin
            check("st_wr_off", {31'b0, mem_wr}, 32'd0);
            check_writes("st", a, sv, n);
        end else
            check("ld_val", load_val, ref_load(t, a));
        @(negedge clk_in);
        ls_enable = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a);
        int lat;
        logic [31:0] exp;
        exp = model_word(a);
        @(negedge clk_in);
        if_req = 1'b1; if_addr = a;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat <= 4) check("if_addr", mem_a, a + lat - 1);
        end while (!if_done && lat < 20);
        check("if_latency", lat, 6);
        check("if_data", if_data, exp);
        @(negedge clk_in);
        if_req = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        logic [3:0]  t;
        logic [3:0]  loads [5];
        logic [3:0]  stores [3];
        int          lat, seen;
        loads  = '{LB, LH, LW, LBU, LHU};
        stores = '{SB, SH, SW};
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            ram[i] <= b;
            model_mem[i] = b;
        end
        repeat (2) tick();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_if_done", {31'b0, if_done}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_finished", {31'b0, ls_finished}, 32'd0);
        check("rst_load_val", load_val, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        do_ls(SW, 32'h100, 32'h00000513);
        do_if(32'h100);
        check("fetch_word", if_data, 32'h00000513);
        do_ls(SB, 32'h20, 32'h000000F0);
        do_ls(SB, 32'h21, 32'h00000080);
        do_ls(LB, 32'h20, 32'h0);
        check("lb_f0", load_val, 32'hFFFFFFF0);
        do_ls(LBU, 32'h20, 32'h0);
        check("lbu_f0", load_val, 32'h000000F0);
        do_ls(LH, 32'h20, 32'h0);
        check("lh_80f0", load_val, 32'hFFFF80F0);
        do_ls(SW, 32'h40, 32'hDEADBEEF);
        do_ls(LW, 32'h40, 32'h0);
        check("lw_deadbeef", load_val, 32'hDEADBEEF);
        do_ls(LW, 32'hFFFFFFFE, 32'h0);

        // both requesters at once: LS first, fetch accepted right after ls_finished
        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = LW; addr = 32'h200; if_req = 1'b1; if_addr = 32'h300;
        lat = 0;
        do begin tick(); lat++; end while (!ls_finished && !if_done && lat < 20);
        check("arb_ls_first", {31'b0, ls_finished}, 32'd1);
        check("arb_if_later", {31'b0, if_done}, 32'd0);
        check("arb_ls_latency", lat, 6);
        check("arb_ld_val", load_val, model_word(32'h200));
        @(negedge clk_in);
        ls_enable = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!if_done && lat < 20);
        check("arb_no_bubble", lat, 6);
        check("arb_if_data", if_data, model_word(32'h300));
        @(negedge clk_in);
        if_req = 1'b0;

        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = LB; addr = 32'h10; clear = 1'b1;
        @(negedge clk_in);
        ls_enable = 1'b0; clear = 1'b0;
        count_pulses(8, seen);
        check("clr_idle_no_accept", seen, 0);

        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h104;
        repeat (2) @(negedge clk_in);
        clear = 1'b1; if_req = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        count_pulses(8, seen);
        check("clr_fetch_no_done", seen, 0);
        do_if(32'h104);

        wq.delete();
        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = SW; addr = 32'h80; store_val = 32'h11223344;
        @(negedge clk_in);
        clear = 1'b1; ls_enable = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        count_pulses(8, seen);
        check("clr_store_no_done", seen, 0);
        check_writes("clr_store", 32'h80, 32'h11223344, 4);
        do_ls(LW, 32'h80, 32'h0);

        // global enable low for two cycles in the middle of a fetch
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h108;
        tick(); tick();
        @(negedge clk_in);
        rdy_in = 1'b0;
        tick();
        check("rdy_hold_a1", mem_a, 32'h109);
        tick();
        check("rdy_hold_a2", mem_a, 32'h109);
        check("rdy_hold_done", {31'b0, if_done}, 32'd0);
        @(negedge clk_in);
        rdy_in = 1'b1;
        lat = 4;
        do begin tick(); lat++; end while (!if_done && lat < 20);
        check("rdy_if_latency", lat, 8);
        check("rdy_if_data", if_data, model_word(32'h108));
        @(negedge clk_in);
        if_req = 1'b0;

        wq.delete();
        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = SW; addr = 32'h88; store_val = 32'hCAFEF00D;
        tick();
        check("rdy_wr_on", {31'b0, mem_wr}, 32'd1);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1 check("rdy_wr_forced", {31'b0, mem_wr}, 32'd0);
        tick();
        check("rdy_wr_forced2", {31'b0, mem_wr}, 32'd0);
        @(negedge clk_in);
        rdy_in = 1'b1;
        lat = 2;
        do begin tick(); lat++; end while (!ls_finished && lat < 20);
        check("rdy_st_latency", lat, 6);
        check_writes("rdy_st", 32'h88, 32'hCAFEF00D, 4);
        @(negedge clk_in);
        ls_enable = 1'b0;

        wq.delete();
        @(negedge clk_in);
        ls_enable = 1'b1; lsb_type = SB; addr = 32'h30000; store_val = 32'h000000A5; io_buffer_full = 1'b1;
`ifdef IO_STALL_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check("io_stall_wr", {31'b0, mem_wr}, 32'd0);
        end
        @(negedge clk_in);
        io_buffer_full = 1'b0;
        tick();
        check("io_resume_wr", {31'b0, mem_wr}, 32'd1);
        check("io_resume_dout", {24'b0, mem_dout}, 32'hA5);
        tick();
        check("io_done", {31'b0, ls_finished}, 32'd1);
`else
        tick();
        check("io_ignored_wr", {31'b0, mem_wr}, 32'd1);
        tick();
        check("io_ignored_done", {31'b0, ls_finished}, 32'd1);
`endif
        @(negedge clk_in);
        ls_enable = 1'b0; io_buffer_full = 1'b0;
        check_writes("io", 32'h30000, 32'h000000A5, 1);

        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h10C;
        tick(); tick();
        @(negedge clk_in);
        rst_in = 1'b1; if_req = 1'b0;
        #1 check("rst_mid_a", mem_a, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        count_pulses(8, seen);
        check("rst_mid_no_done", seen, 0);

        for (int it = 0; it < 80; it++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0: do_if({a[31:2], 2'b00});
                1: begin t = loads[$urandom_range(0, 4)]; do_ls(t, a, 32'h0); end
                default: begin t = stores[$urandom_range(0, 2)]; do_ls(t, a, $urandom); end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
